spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_HALF, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_SETUP, default 4: clk cycles from nCS falling to the first SCLK rising edge, excluding the first low phase; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 4: clk cycles from the last SCLK falling edge to nCS rising; legal range 1..255.
REQ-004 Parameter CS_GAP, default 8: minimum clk cycles nCS stays high between frames; legal range 4..255.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  write request present.
REQ-008 req_ready  output  1  controller is able to accept a request.
REQ-009 req_addr  input  7  target register address.
REQ-010 req_data  input  8  register write data.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 SCLK  output  1  serial clock, SPI mode 0, idle low.
REQ-014 COPI  output  1  serial data, MSB first.
REQ-015 nCS  output  1  active-low chip select.

Function
REQ-016 States SHALL be IDLE, SETUP, LOW, HIGH, HOLD, GAP, driven by one 8-bit phase timer and one 4-bit bit counter.
REQ-017 req_ready SHALL equal (state==IDLE); a handshake occurs only when req_valid && req_ready on a rising clk edge.
REQ-018 On handshake, frame SHALL latch as {1'b1, req_addr, req_data} (16 bits); the state becomes SETUP and nCS goes low with COPI = frame[15] on the next cycle.
REQ-019 req_addr SHALL be transmitted unvalidated; range checking belongs to the peripheral.
REQ-020 SETUP SHALL last CS_SETUP cycles with SCLK=0, then go to LOW.
REQ-021 LOW SHALL last CLK_HALF cycles with SCLK=0, then go to HIGH with SCLK=1 for CLK_HALF cycles.
REQ-022 COPI SHALL change only on entry to LOW, never while SCLK=1, so data is stable across each rising edge.
REQ-023 At the end of HIGH, the bit counter SHALL increment and the next bit SHALL be presented; after the 16th HIGH, the state goes to HOLD.
REQ-024 HOLD SHALL last CS_HOLD cycles with SCLK=0 and nCS=0, then go to GAP.
REQ-025 GAP SHALL hold nCS=1 for CS_GAP cycles, then return to IDLE.
REQ-026 done SHALL pulse for exactly one cycle, on the first GAP cycle.
REQ-027 Exactly 16 SCLK rising edges SHALL occur per nCS-low window.
REQ-028 With default parameters, the nCS-low window SHALL be 4 + 16*8 + 4 = 136 cycles.
REQ-029 req_valid while busy SHALL be ignored; the request is held pending by the requester.
REQ-030 A new handshake SHALL be possible at the earliest on the cycle after GAP ends.
REQ-031 COPI SHALL be 0 whenever nCS=1.

Reset
REQ-032 While rst_n=0, outputs SHALL be: nCS=1, SCLK=0, COPI=0, done=0, busy=0, req_ready=0; state=IDLE and counters are cleared.
REQ-033 Reset asserted mid-frame SHALL abort immediately and asynchronously with no partial-frame completion; done does not pulse.
REQ-034 req_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-035 Package spi_pkg SHALL hold the frame width (16), the write bit position (15), the register address constants 0x00..0x04 (output enables 7_0 and 15_8, PWM enables 7_0 and 15_8, PWM duty cycle), and the controller state enum.
REQ-036 The block SHALL be flat; no sub-module is warranted.
REQ-037 Counter widths SHALL be derived from package constants.

Verification
REQ-038 Write req_addr=0x04, req_data=0x80 (defaults) -> COPI bits sampled at SCLK rising edges are 0x8480, nCS low for 136 cycles, one done pulse; a paired spi_peripheral shows pwm_duty_cycle=0x80.
REQ-039 Back-to-back requests addr 0x00/0xFF then 0x01/0x0F with req_valid held high -> second accepted 8 cycles after nCS rises; peripheral shows en_reg_out_7_0=0xFF and en_reg_out_15_8=0x0F.
REQ-040 Assert req_valid for addr 0x02 while busy -> no second handshake until IDLE; one frame only per accepted request.
REQ-041 rst_n low at the 7th SCLK rising edge -> nCS=1 and SCLK=0 the same cycle, no done; peripheral registers unchanged.
REQ-042 CLK_HALF=2, CS_SETUP=1, CS_HOLD=1, CS_GAP=4, write 0x03/0xA5 -> 66-cycle nCS window; peripheral shows en_reg_pwm_15_8=0xA5.
REQ-043 Write addr 0x05, data 0x11 -> frame 0x8511 transmitted; peripheral registers unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and types for the SPI register-write
//                controller. Holds the frame layout, the peripheral register
//                map and the controller state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame layout: {write flag, 7-bit address, 8-bit data}, MSB first.
  localparam int C_FRAME_W   = 16;
  localparam int C_WRITE_BIT = 15;
  localparam int C_ADDR_W    = 7;
  localparam int C_DATA_W    = 8;

  // The phase timer must cover the largest timing parameter (255).
  localparam int C_TIMER_W   = 8;
  localparam int C_BIT_CNT_W = $clog2(C_FRAME_W);

  // Peripheral register map.
  localparam logic [C_ADDR_W-1:0] C_REG_EN_OUT_7_0  = 7'h00;
  localparam logic [C_ADDR_W-1:0] C_REG_EN_OUT_15_8 = 7'h01;
  localparam logic [C_ADDR_W-1:0] C_REG_EN_PWM_7_0  = 7'h02;
  localparam logic [C_ADDR_W-1:0] C_REG_EN_PWM_15_8 = 7'h03;
  localparam logic [C_ADDR_W-1:0] C_REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } ctrl_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller
//  Description : Single-master SPI (mode 0) write controller. Accepts a
//                register write through a valid/ready handshake and shifts
//                out the 16-bit frame {1, addr, data} MSB first, framed by
//                nCS with programmable setup, hold and inter-frame gap.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                req_valid  - write request present
//                req_ready  - controller can accept a request (IDLE)
//                req_addr   - 7-bit register address
//                req_data   - 8-bit register data
//                busy       - controller is not IDLE
//                done       - one-cycle pulse when a frame completes
//                SCLK       - serial clock, idle low
//                COPI       - serial data out, MSB first
//                nCS        - active-low chip select
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_HALF = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [C_ADDR_W-1:0] req_addr,
  input  logic [C_DATA_W-1:0] req_data,
  output logic                busy,
  output logic                done,
  output logic                SCLK,
  output logic                COPI,
  output logic                nCS
);

  // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
  localparam logic [C_TIMER_W-1:0]   C_SETUP_LAST = C_TIMER_W'(CS_SETUP - 1);
  localparam logic [C_TIMER_W-1:0]   C_HALF_LAST  = C_TIMER_W'(CLK_HALF - 1);
  localparam logic [C_TIMER_W-1:0]   C_HOLD_LAST  = C_TIMER_W'(CS_HOLD - 1);
  localparam logic [C_TIMER_W-1:0]   C_GAP_LAST   = C_TIMER_W'(CS_GAP - 1);
  localparam logic [C_BIT_CNT_W-1:0] C_LAST_BIT   = C_BIT_CNT_W'(C_FRAME_W - 1);
  localparam logic [C_BIT_CNT_W-1:0] C_MSB_INDEX  = C_BIT_CNT_W'(C_WRITE_BIT);

  ctrl_state_t              r_state;
  ctrl_state_t              w_state_next;
  logic [C_TIMER_W-1:0]     r_timer;
  logic [C_BIT_CNT_W-1:0]   r_bit_cnt;
  logic [C_FRAME_W-1:0]     r_frame;
  logic                     r_ready_en;
  logic                     w_handshake;
  logic                     w_phase_end;
  logic                     w_last_bit;

  assign w_handshake = req_valid && req_ready;
  assign w_last_bit  = (r_bit_cnt == C_LAST_BIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_phase_end  = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_phase_end = (r_timer == C_SETUP_LAST);
        if (w_phase_end) w_state_next = ST_LOW;
      end
      ST_LOW: begin
        w_phase_end = (r_timer == C_HALF_LAST);
        if (w_phase_end) w_state_next = ST_HIGH;
      end
      ST_HIGH: begin
        w_phase_end = (r_timer == C_HALF_LAST);
        if (w_phase_end) w_state_next = w_last_bit ? ST_HOLD : ST_LOW;
      end
      ST_HOLD: begin
        w_phase_end = (r_timer == C_HOLD_LAST);
        if (w_phase_end) w_state_next = ST_GAP;
      end
      ST_GAP: begin
        w_phase_end = (r_timer == C_GAP_LAST);
        if (w_phase_end) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase timer, bit counter and frame register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      // Holds req_ready low until the first edge after reset release.
      r_ready_en <= 1'b1;

      // Every state change (including HIGH->LOW between bits) restarts the
      // timer, so each phase counts from zero.
      if (r_state == ST_IDLE || w_state_next != r_state) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_handshake) begin
        r_bit_cnt <= '0;
        r_frame   <= {1'b1, req_addr, req_data};
      end else if (r_state == ST_HIGH && w_phase_end && !w_last_bit) begin
        // Advancing here moves COPI exactly as SCLK falls into LOW.
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    nCS       = 1'b1;
    SCLK      = 1'b0;
    COPI      = 1'b0;
    busy      = (r_state != ST_IDLE);
    req_ready = (r_state == ST_IDLE) && r_ready_en;
    done      = (r_state == ST_GAP) && (r_timer == '0);
    case (r_state)
      ST_SETUP, ST_LOW, ST_HOLD: begin
        nCS  = 1'b0;
        COPI = r_frame[C_MSB_INDEX - r_bit_cnt];
      end
      ST_HIGH: begin
        nCS  = 1'b0;
        SCLK = 1'b1;
        COPI = r_frame[C_MSB_INDEX - r_bit_cnt];
      end
      default: begin
        nCS  = 1'b1;
        COPI = 1'b0;
      end
    endcase
  end

endmodule : spi_controller
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_controller
//  Description : Self-checking bench for spi_controller. Instance 0 uses the
//                default timing, instance 1 the minimum timing. A behavioural
//                peripheral decodes each complete frame into a register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [6:0] req_addr [2];
  logic [7:0] req_data [2];
  logic [1:0] rdy, busy, done, sclk, copi, ncs;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  spi_controller dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rdy[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy[0]),
    .done(done[0]), .SCLK(sclk[0]), .COPI(copi[0]), .nCS(ncs[0])
  );

  spi_controller #(.CLK_HALF(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rdy[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy[1]),
    .done(done[1]), .SCLK(sclk[1]), .COPI(copi[1]), .nCS(ncs[1])
  );

  // ---------------------------------------------------------------- monitor
  logic [15:0] sr [2];
  logic [15:0] last_frame [2];
  int          cur_edges [2];
  int          last_edges [2];
  int          win [2];
  int          last_win [2];
  int          frames [2];
  int          aborted [2];
  int          dones [2];
  int          viol [2];
  int          hs [2];
  logic [1:0]  prev_sclk, prev_ncs, prev_copi, prev_done;
  logic [7:0]  regs [2][5];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sr[i] = '0; last_frame[i] = '0; cur_edges[i] = 0; last_edges[i] = 0;
      win[i] = 0; last_win[i] = 0; frames[i] = 0; aborted[i] = 0;
      dones[i] = 0; viol[i] = 0; hs[i] = 0;
      req_addr[i] = '0; req_data[i] = '0;
      for (int r = 0; r < 5; r++) regs[i][r] = '0;
    end
    prev_sclk = '0; prev_ncs = '1; prev_copi = '0; prev_done = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rst_n && req_valid[i] && rdy[i]) hs[i] <= hs[i] + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        if (!prev_ncs[i]) aborted[i] <= aborted[i] + 1;
        cur_edges[i] <= 0; win[i] <= 0; sr[i] <= '0;
        prev_sclk[i] <= 1'b0; prev_ncs[i] <= 1'b1;
        prev_copi[i] <= 1'b0; prev_done[i] <= 1'b0;
      end else begin
        prev_sclk[i] <= sclk[i]; prev_ncs[i] <= ncs[i];
        prev_copi[i] <= copi[i]; prev_done[i] <= done[i];
        if (ncs[i] && (copi[i] || sclk[i])) viol[i] <= viol[i] + 1;
        if (sclk[i] && prev_sclk[i] && copi[i] != prev_copi[i]) viol[i] <= viol[i] + 1;
        if (done[i] && prev_done[i]) viol[i] <= viol[i] + 1;
        if (done[i]) dones[i] <= dones[i] + 1;
        if (!ncs[i]) win[i] <= win[i] + 1;
        if (sclk[i] && !prev_sclk[i]) begin
          sr[i] <= {sr[i][14:0], copi[i]};
          cur_edges[i] <= cur_edges[i] + 1;
        end
        if (ncs[i] && !prev_ncs[i]) begin
          last_frame[i] <= sr[i]; last_edges[i] <= cur_edges[i];
          last_win[i] <= win[i]; cur_edges[i] <= 0; win[i] <= 0;
          if (cur_edges[i] == 16) begin
            frames[i] <= frames[i] + 1;
            if (sr[i][15] && sr[i][14:8] < 7'd5) regs[i][sr[i][10:8]] <= sr[i][7:0];
          end else begin
            aborted[i] <= aborted[i] + 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Presents a request and returns just after the handshake edge.
  task automatic send(input int i, input logic [6:0] a, input logic [7:0] d, input bit keep);
    int n;
    req_addr[i] = a; req_data[i] = d; req_valid[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 1000) begin @(negedge clk); n++; end
    if (!rdy[i]) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target);
    int n;
    n = 0;
    while (frames[i] < target && n < 2000) begin @(negedge clk); n++; end
    if (frames[i] < target) check("frame_timeout", frames[i], target);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs [6];

  // ---------------------------------------------------------------- test
  initial begin
    int f0, d0, h0, a0, n;

    vecs[0] = '{7'h04, 8'h80, 16'h8480};
    vecs[1] = '{7'h05, 8'h11, 16'h8511};
    vecs[2] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[3] = '{7'h02, 8'h3C, 16'h823C};
    vecs[4] = '{7'h03, 8'hC3, 16'h83C3};
    vecs[5] = '{7'h00, 8'h5A, 16'h805A};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_ncs", ncs[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_copi", copi[0], 0);
    check("rst_done", done[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_ready", rdy[0], 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ready_before_edge", rdy[0], 0);
    @(posedge clk); #1;
    check("ready_first_edge", rdy[0], 1);

    // Table-driven single writes on the default-timing instance
    for (int v = 0; v < 6; v++) begin
      f0 = frames[0]; d0 = dones[0];
      send(0, vecs[v].addr, vecs[v].data, 1'b0);
      wait_frames(0, f0 + 1);
      @(negedge clk);
      check("frame_bits", last_frame[0], vecs[v].exp_frame);
      check("sclk_edges", last_edges[0], 16);
      check("ncs_window", last_win[0], 136);
      check("done_pulses", dones[0] - d0, 1);
    end
    check("reg_duty", regs[0][4], 8'h80);
    check("reg_pwm_7_0", regs[0][2], 8'h3C);
    check("reg_pwm_15_8", regs[0][3], 8'hC3);
    check("reg_out_7_0", regs[0][0], 8'h5A);
    check("reg_out_15_8_untouched", regs[0][1], 8'h00);

    // Back-to-back requests with req_valid held high
    f0 = frames[0];
    send(0, 7'h00, 8'hFF, 1'b1);
    req_addr[0] = 7'h01; req_data[0] = 8'h0F;
    n = 0;
    while (!ncs[0] && n < 500) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
    check("b2b_ready_delay", n + 1, 8);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    wait_frames(0, f0 + 2);
    @(negedge clk);
    check("b2b_frame2", last_frame[0], 16'h810F);
    check("b2b_out_7_0", regs[0][0], 8'hFF);
    check("b2b_out_15_8", regs[0][1], 8'h0F);

    // Request presented while busy is held off until IDLE
    f0 = frames[0]; h0 = hs[0];
    send(0, 7'h03, 8'h11, 1'b0);
    req_addr[0] = 7'h02; req_data[0] = 8'h77; req_valid[0] = 1'b1;
    wait_frames(0, f0 + 1);
    check("busy_hs_first", hs[0] - h0, 1);
    check("busy_frame1", last_frame[0], 16'h8311);
    n = 0;
    while (!rdy[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1; req_valid[0] = 1'b0;
    wait_frames(0, f0 + 2);
    @(negedge clk);
    check("busy_hs_total", hs[0] - h0, 2);
    check("busy_frame2", last_frame[0], 16'h8277);
    check("busy_reg_pwm_7_0", regs[0][2], 8'h77);

    // Reset asserted at the 7th SCLK rising edge aborts the frame
    f0 = frames[0]; d0 = dones[0]; a0 = aborted[0];
    send(0, 7'h01, 8'h55, 1'b0);
    n = 0;
    while (cur_edges[0] < 7 && n < 500) begin @(negedge clk); n++; end
    #1 rst_n = 1'b0; #1;
    check("abort_ncs", ncs[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_done", done[0], 0);
    check("abort_busy", busy[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_counted", aborted[0] - a0, 1);
    check("abort_no_frame", frames[0] - f0, 0);
    check("abort_no_done", dones[0] - d0, 0);
    check("abort_reg_kept", regs[0][1], 8'h0F);

    // Minimum-timing instance
    d0 = dones[1];
    send(1, 7'h03, 8'hA5, 1'b0);
    wait_frames(1, 1);
    @(negedge clk);
    check("fast_frame", last_frame[1], 16'h83A5);
    check("fast_edges", last_edges[1], 16);
    check("fast_window", last_win[1], 66);
    check("fast_done", dones[1] - d0, 1);
    check("fast_reg_pwm_15_8", regs[1][3], 8'hA5);

    // Continuous protocol invariants
    check("invariants_a", viol[0], 0);
    check("invariants_b", viol[1], 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_spi_controller
`default_nettype wire
